// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives the instruction ROM address and registers {word, PC, PC+1} for decode.
// Optional event counters are built only when the FETCH_PERF_EN macro is defined.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redir_valid,
    input  logic [1:0]               redir_kind,
    input  logic signed [15:0]       redir_off,
    input  logic [25:0]              redir_abs,
    input  logic [31:0]              redir_reg,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_data,
    output logic [DATA_W-1:0]        if_instr,
    output logic [ADDR_W-1:0]        if_pc,
    output logic [ADDR_W-1:0]        if_pc_plus1,
    output logic                     if_valid,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_bubbles
);

    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    typedef enum logic {
        ST_BUBBLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_target;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_if_pc;
    logic [ADDR_W-1:0]   r_if_pc1;
    logic                w_take;
    logic                w_adv;
    logic                w_unused_bits;

    // Branch offsets are relative to the instruction after the branch, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0]  pc,
        input logic signed [15:0] off
    );
        return pc + ONE + ADDR_W'(off);
    endfunction

    // Only the low ADDR_W bits of the redirect operands address the ROM.
    assign w_unused_bits = ^{redir_off, redir_abs, redir_reg};

    always_comb begin
        w_take      = 1'b0;
        w_adv       = 1'b0;
        w_target    = r_pc;
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;

        // A redirect is only trusted when it comes from a real instruction in IF/ID.
        w_take = redir_valid && (r_state == ST_RUN) && (redir_kind != 2'b11);
        w_adv  = w_take || !stall;

        case (redir_kind)
            2'b00:   w_target = branch_target(r_if_pc, redir_off);
            2'b01:   w_target = redir_abs[ADDR_W-1:0];
            2'b10:   w_target = redir_reg[ADDR_W-1:0];
            default: w_target = r_pc;
        endcase

        if (w_take) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_BUBBLE;
        end else if (!stall) begin
            w_pc_nxt    = r_pc + ONE;
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BUBBLE;
            r_pc    <= RESET_PC_V;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // On a redirect edge the word behind the branch still loads; the bubble state marks it invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr  <= '0;
            r_if_pc  <= '0;
            r_if_pc1 <= ONE;
        end else if (w_adv) begin
            r_instr  <= imem_data;
            r_if_pc  <= r_pc;
            r_if_pc1 <= r_pc + ONE;
        end
    end

    assign imem_addr   = r_pc;
    assign if_instr    = r_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus1 = r_if_pc1;
    assign if_valid    = (r_state == ST_RUN);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Every advancing edge retires what IF/ID held: a real instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else if (w_adv) begin
            if (r_state == ST_RUN) begin
                r_perf_fetched <= sat_inc(r_perf_fetched);
            end else begin
                r_perf_bubbles <= sat_inc(r_perf_bubbles);
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed redirect/stall sequence plus a RESET_PC=255 wrap instance.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               stall;
    logic               redir_valid;
    logic [1:0]         redir_kind;
    logic signed [15:0] redir_off;
    logic [25:0]        redir_abs;
    logic [31:0]        redir_reg;
    logic [7:0]         imem_addr;
    logic [31:0]        imem_data;
    logic [31:0]        if_instr;
    logic [7:0]         if_pc;
    logic [7:0]         if_pc_plus1;
    logic               if_valid;
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_bubbles;

    logic               w_stall;
    logic               w_rv;
    logic [1:0]         w_kind;
    logic signed [15:0] w_off;
    logic [25:0]        w_abs;
    logic [31:0]        w_reg;
    logic [7:0]         w_imem_addr;
    logic [31:0]        w_imem_data;
    logic [31:0]        w_if_instr;
    logic [7:0]         w_if_pc;
    logic [7:0]         w_if_pc1;
    logic               w_if_valid;
    logic [31:0]        w_perf_f;
    logic [31:0]        w_perf_b;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return {8'hC0, a, ~a, a ^ 8'h5A};
    endfunction

    assign imem_data   = rom(imem_addr);
    assign w_imem_data = rom(w_imem_addr);

    fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
        .redir_kind(redir_kind), .redir_off(redir_off), .redir_abs(redir_abs),
        .redir_reg(redir_reg), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
        .if_valid(if_valid), .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
    );

    fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(255)) dut_wrap (
        .clk(clk), .rst(rst), .stall(w_stall), .redir_valid(w_rv),
        .redir_kind(w_kind), .redir_off(w_off), .redir_abs(w_abs),
        .redir_reg(w_reg), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc_plus1(w_if_pc1),
        .if_valid(w_if_valid), .perf_fetched(w_perf_f), .perf_bubbles(w_perf_b)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic [7:0]  pc1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic was_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] pc, input logic [7:0] pc1);
        exp_t e;
        e.instr = rom(pc);
        e.pc    = pc;
        e.pc1   = pc1;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall       = 1'b0;
        redir_valid = 1'b0;
    endtask

    task automatic redir(input logic [1:0] kind, input logic signed [15:0] off,
                         input logic [25:0] abs_t, input logic [31:0] reg_t);
        redir_valid = 1'b1;
        redir_kind  = kind;
        redir_off   = off;
        redir_abs   = abs_t;
        redir_reg   = reg_t;
    endtask

    task automatic chk_perf(input string tag, input int f, input int b);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetched"}, perf_fetched, 32'(f));
        chk({tag, "_perf_bubbles"}, perf_bubbles, 32'(b));
`else
        chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
        chk({tag, "_perf_bubbles"}, perf_bubbles, 32'd0);
`endif
    endtask

    // Monitor: every freshly loaded valid IF/ID word must match the head of the queue.
    always @(posedge clk) was_stall <= stall;

    always @(negedge clk) begin
        if (!was_stall && if_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h required no output", if_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("if_instr", if_instr, e.instr);
                chk("if_pc", 32'(if_pc), 32'(e.pc));
                chk("if_pc_plus1", 32'(if_pc_plus1), 32'(e.pc1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_kind = 2'b00;
        redir_off = '0; redir_abs = '0; redir_reg = '0;
        w_stall = 1'b0; w_rv = 1'b0; w_kind = 2'b00; w_off = '0; w_abs = '0; w_reg = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_imem_addr", 32'(imem_addr), 32'h00);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'h00);
        chk("rst_if_pc_plus1", 32'(if_pc_plus1), 32'h01);
        chk("rst_if_instr", if_instr, 32'h0);
        chk_perf("rst", 0, 0);
        chk("wrap_rst_imem_addr", 32'(w_imem_addr), 32'hFF);

        push(8'h00, 8'h01); tick();
        chk("wrap_if_pc_255", 32'(w_if_pc), 32'hFF);
        chk("wrap_if_pc_plus1", 32'(w_if_pc1), 32'h00);
        chk("wrap_imem_addr_0", 32'(w_imem_addr), 32'h00);
        chk("wrap_if_valid", 32'(w_if_valid), 32'd1);
        push(8'h01, 8'h02); tick();
        chk("wrap_if_pc_0", 32'(w_if_pc), 32'h00);
        chk("wrap_imem_addr_1", 32'(w_imem_addr), 32'h01);
        push(8'h02, 8'h03); tick();
        push(8'h03, 8'h04); tick();
        push(8'h04, 8'h05); tick();
        push(8'h05, 8'h06); tick();
        push(8'h06, 8'h07); tick();
        chk("seq_imem_addr", 32'(imem_addr), 32'h07);

        // branch -5 from if_pc 6 lands on 2
        redir(2'b00, -16'sd5, 26'h0, 32'h0); tick(); idle();
        chk("branch_imem_addr", 32'(imem_addr), 32'h02);
        chk("branch_bubble", 32'(if_valid), 32'd0);
        push(8'h02, 8'h03); tick();
        push(8'h03, 8'h04); tick();

        redir(2'b01, 16'sd0, 26'h0000103, 32'h0); tick(); idle();
        chk("jump_imem_addr", 32'(imem_addr), 32'h03);
        chk("jump_bubble", 32'(if_valid), 32'd0);
        push(8'h03, 8'h04); tick();
        chk_perf("mid", 9, 3);

        redir(2'b10, 16'sd0, 26'h0, 32'h0000010A); tick(); idle();
        chk("jr_imem_addr", 32'(imem_addr), 32'h0A);
        push(8'h0A, 8'h0B); tick();

        redir(2'b01, 16'sd0, 26'h0000007, 32'h0); tick(); idle();
        chk("jal_imem_addr", 32'(imem_addr), 32'h07);
        push(8'h07, 8'h08); tick();

        // branch -4 from if_pc 7 lands on 4; then stall with PC=5
        redir(2'b00, -16'sd4, 26'h0, 32'h0); tick(); idle();
        chk("branch2_imem_addr", 32'(imem_addr), 32'h04);
        push(8'h04, 8'h05); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_imem_addr", 32'(imem_addr), 32'h05);
            chk("stall_if_pc", 32'(if_pc), 32'h04);
            chk("stall_if_instr", if_instr, 32'hC004FB5E);
        end

        // stall and branch +2 in the same cycle: redirect wins, 4+1+2 = 7
        redir(2'b00, 16'sd2, 26'h0, 32'h0); tick();
        chk("stall_redir_imem_addr", 32'(imem_addr), 32'h07);
        chk("stall_redir_bubble", 32'(if_valid), 32'd0);

        // redirect offered during the bubble is ignored
        stall = 1'b0;
        redir(2'b01, 16'sd0, 26'h0000050, 32'h0);
        push(8'h07, 8'h08); tick();
        chk("bubble_redir_ignored", 32'(imem_addr), 32'h08);

        // reserved kind is treated as no redirect
        redir(2'b11, 16'sd0, 26'h0000050, 32'h00000050);
        push(8'h08, 8'h09); tick();
        chk("reserved_kind_ignored", 32'(imem_addr), 32'h09);
        idle();
        push(8'h09, 8'h0A); tick();
        chk_perf("end", 15, 7);

        // reset beats a simultaneous stall and redirect
        rst = 1'b1; stall = 1'b1;
        redir(2'b01, 16'sd0, 26'h0000033, 32'h0); tick();
        rst = 1'b0; idle();
        chk("rst2_imem_addr", 32'(imem_addr), 32'h00);
        chk("rst2_if_valid", 32'(if_valid), 32'd0);
        chk("rst2_if_pc", 32'(if_pc), 32'h00);
        chk("rst2_if_pc_plus1", 32'(if_pc_plus1), 32'h01);
        chk("rst2_if_instr", if_instr, 32'h0);
        chk_perf("rst2", 0, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
